// File: rtl/run_cmd_issuer.sv
// run_cmd_issuer: initiator side of the go/stop/running control interface.
// Turns START/PAUSE/RESUME/ABORT commands into go/stop pulses toward a
// run-engine, confirms each step on running (with timeout), and keeps a
// shadow copy of the engine state so divergence can be flagged as a fault.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a command; watches running against the shadow
// S_PULSE  | go or stop pulse is on the wire this cycle
// S_WAIT   | waiting for running to reach the expected level (timeout)
// S_SETTLE | blind wait after a stop whose effect running cannot show
// S_RESP   | done/err presented for one cycle, then back to S_IDLE
module run_cmd_issuer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       go,
  output logic       stop,
  input  logic       running,
  output logic       done,
  output logic       err,
  output logic       fault,
  output logic [1:0] shadow_state
);

  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_SAT    = CW'(CMAX);
  localparam logic [CW-1:0] CNT_TO     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  localparam logic [1:0] SH_IDLE  = 2'b00;
  localparam logic [1:0] SH_RUN   = 2'b01;
  localparam logic [1:0] SH_PAUSE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            wait_level;  // running level that confirms the current step
  logic            use_wait;    // first pulse is confirmed by running, else settled blind
  logic            two_pulse;   // sequence needs a second stop pulse
  logic            second;      // currently in the second-pulse leg
  logic            clr_fault;   // this command is a blind recovery
  logic [1:0]      fin_shadow;  // shadow value to commit on success
  logic            mm_prev;     // running disagreed with shadow last idle cycle
  logic            phase_done;
  logic            shadow_run;

  assign shadow_run = (shadow_state == SH_RUN);

  // A step is finished when running confirms it, or the blind settle time expired.
  assign phase_done = ((state == S_WAIT) && (running == wait_level)) ||
                      ((state == S_SETTLE) && (cnt >= CNT_SETTLE));

  // Command sequencer with registered handshake, pulse and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cmd_ready    <= 1'b0;
      go           <= 1'b0;
      stop         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      fault        <= 1'b0;
      shadow_state <= SH_IDLE;
      wait_level   <= 1'b0;
      use_wait     <= 1'b0;
      two_pulse    <= 1'b0;
      second       <= 1'b0;
      clr_fault    <= 1'b0;
      fin_shadow   <= SH_IDLE;
      mm_prev      <= 1'b0;
    end else begin
      go   <= 1'b0;
      stop <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          cnt       <= '0;
          second    <= 1'b0;
          // Two consecutive disagreeing cycles are needed so a single-cycle
          // glitch on running does not latch a fault.
          if (running != shadow_run) begin
            if (mm_prev) fault <= 1'b1;
            mm_prev <= 1'b1;
          end else begin
            mm_prev <= 1'b0;
          end
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            mm_prev    <= 1'b0;
            clr_fault  <= 1'b0;
            two_pulse  <= 1'b0;
            use_wait   <= 1'b1;
            if (cmd_op == OP_ABORT) begin
              fin_shadow <= SH_IDLE;
              wait_level <= 1'b0;
              if (fault) begin
                // Engine state is untrusted: two blind stops reach IDLE from anywhere.
                stop      <= 1'b1;
                use_wait  <= 1'b0;
                two_pulse <= 1'b1;
                clr_fault <= 1'b1;
                state     <= S_PULSE;
              end else if (shadow_state == SH_RUN) begin
                stop      <= 1'b1;
                two_pulse <= 1'b1;
                state     <= S_PULSE;
              end else if (shadow_state == SH_PAUSE) begin
                stop     <= 1'b1;
                use_wait <= 1'b0;
                state    <= S_PULSE;
              end else begin
                done         <= 1'b1;
                shadow_state <= SH_IDLE;
                state        <= S_RESP;
              end
            end else if (!fault && (((cmd_op == OP_START) && (shadow_state == SH_IDLE)) ||
                                    ((cmd_op == OP_RESUME) && (shadow_state == SH_PAUSE)))) begin
              go         <= 1'b1;
              wait_level <= 1'b1;
              fin_shadow <= SH_RUN;
              state      <= S_PULSE;
            end else if (!fault && (cmd_op == OP_PAUSE) && (shadow_state == SH_RUN)) begin
              stop       <= 1'b1;
              wait_level <= 1'b0;
              fin_shadow <= SH_PAUSE;
              state      <= S_PULSE;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_PULSE: begin
          cnt   <= '0;
          state <= (use_wait && !second) ? S_WAIT : S_SETTLE;
        end
        S_WAIT, S_SETTLE: begin
          if (phase_done) begin
            if (two_pulse && !second) begin
              stop   <= 1'b1;
              second <= 1'b1;
              state  <= S_PULSE;
            end else begin
              done         <= 1'b1;
              shadow_state <= fin_shadow;
              if (clr_fault) fault <= 1'b0;
              state        <= S_RESP;
            end
          end else if ((state == S_WAIT) && (cnt >= CNT_TO)) begin
            done  <= 1'b1;
            err   <= 1'b1;
            fault <= 1'b1;
            state <= S_RESP;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_cmd_issuer.sv
// Directed bench for run_cmd_issuer with a behavioural run-engine model.
module tb_run_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, go, stop, running, done, err, fault;
  logic [1:0] shadow_state;

  logic [1:0] eng_state;
  logic       eng_run;
  logic       freeze = 1'b0;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;
  int stop_cnt = 0;
  int overlap = 0;

  run_cmd_issuer #(.TIMEOUT_CYCLES(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .go(go), .stop(stop), .running(running), .done(done),
    .err(err), .fault(fault), .shadow_state(shadow_state)
  );

  always #5 clk = ~clk;

  // Ideal engine: go/stop move the state, running is a registered copy of RUN.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_state <= 2'd0;
      eng_run   <= 1'b0;
    end else begin
      eng_run <= (eng_state == 2'd1);
      if (!freeze) begin
        if (go && (eng_state != 2'd1)) eng_state <= 2'd1;
        else if (stop && (eng_state == 2'd1)) eng_state <= 2'd2;
        else if (stop && (eng_state == 2'd2)) eng_state <= 2'd0;
      end
    end
  end

  assign running = force_en ? force_val : eng_run;

  always @(posedge clk) begin
    if (go === 1'b1) go_cnt++;
    if (stop === 1'b1) stop_cnt++;
    if ((go === 1'b1) && (stop === 1'b1)) overlap++;
  end

  // Issue one command; lat = edges after acceptance until done is seen.
  task automatic send_cmd(input logic [1:0] op, output int lat, output logic err_v,
                          output logic go0, output logic stop0);
    int b;
    b = 0;
    while ((cmd_ready !== 1'b1) && (b < 20)) begin
      @(posedge clk); #1; b++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    go0   = go;
    stop0 = stop;
    lat   = 0;
    while ((done !== 1'b1) && (lat < 40)) begin
      @(posedge clk); #1; lat++;
    end
    err_v = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", cmd_ready); end
    tests++; if ({go, stop, done, err, fault} !== 5'b0) begin fails++; $display("FAIL rst_outs: got %b expected 00000", {go, stop, done, err, fault}); end
    tests++; if (shadow_state !== 2'b00) begin fails++; $display("FAIL rst_shadow: got %b expected 00", shadow_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rise: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_start;
    int lat; logic e, g0, s0; int gb, sb;
    gb = go_cnt; sb = stop_cnt;
    send_cmd(2'b00, lat, e, g0, s0);
    tests++; if ({g0, s0} !== 2'b10) begin fails++; $display("FAIL start_pulse: got go,stop=%b expected 10", {g0, s0}); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL start_lat: got %0d expected 3", lat); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL start_err: got %b expected 0", e); end
    tests++; if (shadow_state !== 2'b01) begin fails++; $display("FAIL start_shadow: got %b expected 01", shadow_state); end
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL start_running: got %b expected 1", running); end
    tests++; if ((go_cnt - gb) !== 1 || (stop_cnt - sb) !== 0) begin fails++; $display("FAIL start_count: got go %0d stop %0d expected 1 0", go_cnt - gb, stop_cnt - sb); end
  endtask

  task automatic test_sequence;
    int lat; logic e, g0, s0; int gb, sb;
    gb = go_cnt; sb = stop_cnt;
    send_cmd(2'b01, lat, e, g0, s0);
    tests++; if (lat !== 3 || e !== 1'b0 || s0 !== 1'b1 || shadow_state !== 2'b10) begin fails++; $display("FAIL pause: got lat %0d err %b stop %b shadow %b expected 3 0 1 10", lat, e, s0, shadow_state); end
    send_cmd(2'b10, lat, e, g0, s0);
    tests++; if (lat !== 3 || e !== 1'b0 || g0 !== 1'b1 || shadow_state !== 2'b01) begin fails++; $display("FAIL resume: got lat %0d err %b go %b shadow %b expected 3 0 1 01", lat, e, g0, shadow_state); end
    send_cmd(2'b01, lat, e, g0, s0);
    tests++; if (lat !== 3 || shadow_state !== 2'b10) begin fails++; $display("FAIL pause2: got lat %0d shadow %b expected 3 10", lat, shadow_state); end
    send_cmd(2'b11, lat, e, g0, s0);
    tests++; if (lat !== 3 || e !== 1'b0 || shadow_state !== 2'b00 || eng_state !== 2'd0) begin fails++; $display("FAIL abort_pause: got lat %0d err %b shadow %b eng %0d expected 3 0 00 0", lat, e, shadow_state, eng_state); end
    tests++; if ((go_cnt - gb) !== 1 || (stop_cnt - sb) !== 3) begin fails++; $display("FAIL seq_count: got go %0d stop %0d expected 1 3", go_cnt - gb, stop_cnt - sb); end
    send_cmd(2'b00, lat, e, g0, s0);
    gb = go_cnt; sb = stop_cnt;
    send_cmd(2'b11, lat, e, g0, s0);
    tests++; if (lat !== 6 || e !== 1'b0 || shadow_state !== 2'b00 || eng_state !== 2'd0) begin fails++; $display("FAIL abort_run: got lat %0d err %b shadow %b eng %0d expected 6 0 00 0", lat, e, shadow_state, eng_state); end
    tests++; if ((go_cnt - gb) !== 0 || (stop_cnt - sb) !== 2) begin fails++; $display("FAIL abort_run_count: got go %0d stop %0d expected 0 2", go_cnt - gb, stop_cnt - sb); end
  endtask

  task automatic test_illegal;
    int lat; logic e, g0, s0; int gb, sb;
    gb = go_cnt; sb = stop_cnt;
    send_cmd(2'b01, lat, e, g0, s0);
    tests++; if (lat !== 0 || e !== 1'b1) begin fails++; $display("FAIL illegal_pause: got lat %0d err %b expected 0 1", lat, e); end
    tests++; if ((go_cnt - gb) !== 0 || (stop_cnt - sb) !== 0 || shadow_state !== 2'b00) begin fails++; $display("FAIL illegal_side: got go %0d stop %0d shadow %b expected 0 0 00", go_cnt - gb, stop_cnt - sb, shadow_state); end
    send_cmd(2'b11, lat, e, g0, s0);
    tests++; if (lat !== 0 || e !== 1'b0 || (stop_cnt - sb) !== 0) begin fails++; $display("FAIL abort_idle: got lat %0d err %b stops %0d expected 0 0 0", lat, e, stop_cnt - sb); end
  endtask

  task automatic test_timeout;
    int lat; logic e, g0, s0; int gb, sb;
    freeze = 1'b1;
    send_cmd(2'b00, lat, e, g0, s0);
    tests++; if (g0 !== 1'b1 || lat !== 17 || e !== 1'b1) begin fails++; $display("FAIL timeout: got go %b lat %0d err %b expected 1 17 1", g0, lat, e); end
    tests++; if (fault !== 1'b1 || shadow_state !== 2'b00) begin fails++; $display("FAIL timeout_fault: got fault %b shadow %b expected 1 00", fault, shadow_state); end
    gb = go_cnt;
    send_cmd(2'b00, lat, e, g0, s0);
    tests++; if (lat !== 0 || e !== 1'b1 || (go_cnt - gb) !== 0) begin fails++; $display("FAIL fault_reject: got lat %0d err %b gos %0d expected 0 1 0", lat, e, go_cnt - gb); end
    sb = stop_cnt;
    send_cmd(2'b11, lat, e, g0, s0);
    tests++; if (lat !== 6 || e !== 1'b0 || (stop_cnt - sb) !== 2) begin fails++; $display("FAIL recover: got lat %0d err %b stops %0d expected 6 0 2", lat, e, stop_cnt - sb); end
    tests++; if (fault !== 1'b0 || shadow_state !== 2'b00) begin fails++; $display("FAIL recover_state: got fault %b shadow %b expected 0 00", fault, shadow_state); end
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_op = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tests++; if (go !== 1'b1) begin fails++; $display("FAIL mid_go: got %b expected 1", go); end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++; if ({go, done, fault, cmd_ready} !== 4'b0 || shadow_state !== 2'b00) begin fails++; $display("FAIL mid_reset: got go,done,fault,ready %b shadow %b expected 0000 00", {go, done, fault, cmd_ready}, shadow_state); end
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL mid_hold: got %b expected 0", cmd_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_release: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_idle_mismatch;
    int lat; logic e, g0, s0; int gb, sb;
    send_cmd(2'b00, lat, e, g0, s0);
    gb = go_cnt; sb = stop_cnt;
    force_en = 1'b1; force_val = 1'b0;
    @(posedge clk); #1;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL mm_one: got %b expected 0", fault); end
    @(posedge clk); #1;
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL mm_two: got %b expected 1", fault); end
    force_en = 1'b0;
    tests++; if ((go_cnt - gb) !== 0 || (stop_cnt - sb) !== 0 || shadow_state !== 2'b01) begin fails++; $display("FAIL mm_quiet: got go %0d stop %0d shadow %b expected 0 0 01", go_cnt - gb, stop_cnt - sb, shadow_state); end
    send_cmd(2'b11, lat, e, g0, s0);
    tests++; if (lat !== 6 || fault !== 1'b0 || shadow_state !== 2'b00 || eng_state !== 2'd0) begin fails++; $display("FAIL mm_recover: got lat %0d fault %b shadow %b eng %0d expected 6 0 00 0", lat, fault, shadow_state, eng_state); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_sequence;
    test_illegal;
    test_timeout;
    test_reset_mid;
    test_idle_mismatch;
    tests++; if (overlap !== 0) begin fails++; $display("FAIL go_stop_overlap: got %0d expected 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
